// File: rtl/bit_serializer_if.sv
// Word-in / bit-out bundle between a word producer, the serializer and the serial detector.
// master drives words and flush; slave is the serializer presenting the serial stream.
interface bit_serializer_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] din;
   logic             din_valid;
   logic             din_ready;
   logic             flush;
   logic             sout;
   logic             sout_valid;
   logic             word_last;
   logic             busy;

   modport master (
      output din, din_valid, flush,
      input  din_ready, sout, sout_valid, word_last, busy
   );

   modport slave (
      input  din, din_valid, flush,
      output din_ready, sout, sout_valid, word_last, busy
   );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: one-word hold register feeding a WIDTH-bit shifter, one bit per clock.
// Latency: first bit on sout the cycle after the edge following accept; back-to-back words stream gaplessly.
// Backpressure: din_ready low while the hold register is occupied or flush is asserted.
module bit_serializer #(
   parameter int WIDTH      = 8,
   parameter bit LSB_FIRST  = 1'b0,
   parameter bit IDLE_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   bit_serializer_if.slave  bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] hold;
   logic [WIDTH-1:0] shreg;
   logic             hold_full;
   logic [CW-1:0]    cnt;

   logic accept;
   logic unload;
   logic head;

   assign bus.din_ready = !hold_full && !bus.flush;
   assign accept        = bus.din_valid && bus.din_ready;
   // The hold empties into the shifter whenever the shifter is free or on its last bit.
   assign unload        = hold_full && ((state == IDLE) || (cnt == '0));

   assign head           = LSB_FIRST ? shreg[0] : shreg[WIDTH-1];
   assign bus.sout_valid = (state == SHIFT);
   assign bus.word_last  = (state == SHIFT) && (cnt == '0);
   assign bus.sout       = (state == SHIFT) ? head : IDLE_LEVEL;
   assign bus.busy       = (state == SHIFT) || hold_full;

   function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
      if (LSB_FIRST)
         return {1'b0, v[WIDTH-1:1]};
      else
         return {v[WIDTH-2:0], 1'b0};
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         hold      <= '0;
         hold_full <= 1'b0;
         shreg     <= '0;
         cnt       <= '0;
      end else if (bus.flush) begin
         state     <= IDLE;
         hold_full <= 1'b0;
         cnt       <= '0;
      end else begin
         if (unload) begin
            shreg <= hold;
            cnt   <= CW'(WIDTH - 1);
            state <= SHIFT;
         end else if (state == SHIFT) begin
            if (cnt == '0) begin
               state <= IDLE;
            end else begin
               shreg <= advance(shreg);
               cnt   <= cnt - CW'(1);
            end
         end

         // accept requires an empty hold and unload a full one, so these never coincide.
         if (accept) begin
            hold      <= bus.din;
            hold_full <= 1'b1;
         end else if (unload) begin
            hold_full <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: MSB-first and LSB-first instances share one stimulus stream,
// compared each cycle against a word-level queue model plus an end-to-end word scoreboard.
module tb_bit_serializer;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] din = '0;
   logic       din_valid = 1'b0;
   logic       flush = 1'b0;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   bit_serializer_if #(.WIDTH(8)) if_m ();
   bit_serializer_if #(.WIDTH(8)) if_l ();

   assign if_m.din = din;
   assign if_m.din_valid = din_valid;
   assign if_m.flush = flush;
   assign if_l.din = din;
   assign if_l.din_valid = din_valid;
   assign if_l.flush = flush;

   bit_serializer #(.WIDTH(8), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_m (
      .clk(clk), .rst_n(rst_n), .bus(if_m)
   );
   bit_serializer #(.WIDTH(8), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u_l (
      .clk(clk), .rst_n(rst_n), .bus(if_l)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Word-level model: current word with bits remaining, plus at most one waiting word.
   logic [7:0] m_cur = '0;
   int         m_left = 0;
   logic [7:0] m_held[$];
   logic [7:0] sb_m[$];
   logic [7:0] sb_l[$];
   bit         m_rdy;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_left = 0;
         m_held.delete();
         sb_m.delete();
         sb_l.delete();
      end else begin
         m_rdy = (m_held.size() == 0) && !flush;
         if (flush) begin
            m_left = 0;
            m_held.delete();
            sb_m.delete();
            sb_l.delete();
         end else begin
            if (m_left > 1) begin
               m_left--;
            end else begin
               m_left = 0;
               if (m_held.size() > 0) begin
                  m_cur  = m_held.pop_front();
                  m_left = 8;
               end
            end
            if (din_valid && m_rdy) begin
               m_held.push_back(din);
               sb_m.push_back(din);
               sb_l.push_back(din);
            end
         end
      end
   end

   logic [7:0] col_m = '0;
   logic [7:0] col_l = '0;
   int         run_len = 0;
   int         last_run = 0;
   int         k;
   logic       e_m, e_l, e_vld, e_last, e_busy, e_rdy;

   always @(negedge clk) begin
      e_vld  = (m_left > 0);
      e_last = (m_left == 1);
      e_busy = e_vld || (m_held.size() > 0);
      e_rdy  = (m_held.size() == 0) && !flush && rst_n;
      if (e_vld) begin
         k   = 8 - m_left;
         e_m = m_cur[7-k];
         e_l = m_cur[k];
      end else begin
         e_m = 1'b0;
         e_l = 1'b1;
      end
      if (!rst_n) e_rdy = 1'b1;
      check("sout_m", {31'd0, if_m.sout}, {31'd0, e_m});
      check("sout_l", {31'd0, if_l.sout}, {31'd0, e_l});
      check("vld_m", {31'd0, if_m.sout_valid}, {31'd0, e_vld});
      check("vld_l", {31'd0, if_l.sout_valid}, {31'd0, e_vld});
      check("last_m", {31'd0, if_m.word_last}, {31'd0, e_last});
      check("last_l", {31'd0, if_l.word_last}, {31'd0, e_last});
      check("busy_m", {31'd0, if_m.busy}, {31'd0, e_busy});
      check("rdy_m", {31'd0, if_m.din_ready}, {31'd0, e_rdy});
      check("rdy_l", {31'd0, if_l.din_ready}, {31'd0, e_rdy});

      if (!rst_n) begin
         run_len  = 0;
         last_run = 0;
      end else begin
         if (if_m.sout_valid) begin
            col_m = {col_m[6:0], if_m.sout};
            run_len++;
            if (if_m.word_last) begin
               if (sb_m.size() == 0) check("sb_m_extra", 32'd1, 32'd0);
               else check("word_m", {24'd0, col_m}, {24'd0, sb_m.pop_front()});
            end
         end else if (run_len > 0) begin
            last_run = run_len;
            run_len  = 0;
         end
         if (if_l.sout_valid) begin
            col_l = {if_l.sout, col_l[7:1]};
            if (if_l.word_last) begin
               if (sb_l.size() == 0) check("sb_l_extra", 32'd1, 32'd0);
               else check("word_l", {24'd0, col_l}, {24'd0, sb_l.pop_front()});
            end
         end
      end
   end

   // Present w until it is taken; returns 1 ns after the accepting edge.
   task automatic send(input logic [7:0] w);
      logic acc;
      din       = w;
      din_valid = 1'b1;
      acc       = 1'b0;
      for (int i = 0; i < 100 && !acc; i++) begin
         @(negedge clk);
         acc = if_m.din_ready;
         @(posedge clk);
         #1;
      end
      if (!acc) check("send_timeout", 32'd0, 32'd1);
      din_valid = 1'b0;
   endtask

   logic [7:0] b4 = 8'hB4;

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rst_sout", {31'd0, if_m.sout}, 32'd0);
      check("rst_rdy", {31'd0, if_m.din_ready}, 32'd1);
      rst_n = 1'b1;

      // single word, both bit orders
      send(b4);
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("b4_msb_bit", {31'd0, if_m.sout}, {31'd0, b4[7-i]});
         check("b4_lsb_bit", {31'd0, if_l.sout}, {31'd0, b4[i]});
         check("b4_last", {31'd0, if_m.word_last}, (i == 7) ? 32'd1 : 32'd0);
      end
      @(negedge clk);
      check("b4_idle_vld", {31'd0, if_m.sout_valid}, 32'd0);
      check("b4_idle_busy", {31'd0, if_m.busy}, 32'd0);
      check("b4_idle_lvl_l", {31'd0, if_l.sout}, 32'd1);

      // back-to-back words stream without a gap
      @(posedge clk);
      #1;
      send(8'hB4);
      send(8'h5A);
      repeat (25) @(negedge clk);
      check("b2b_run", last_run, 32'd16);

      // flush with one word shifting and one held
      @(posedge clk);
      #1;
      send(8'hB4);
      send(8'h5A);
      @(posedge clk);
      @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      @(negedge clk);
      check("fl_vld", {31'd0, if_m.sout_valid}, 32'd0);
      check("fl_busy", {31'd0, if_m.busy}, 32'd0);
      check("fl_sout_m", {31'd0, if_m.sout}, 32'd0);
      check("fl_sout_l", {31'd0, if_l.sout}, 32'd1);
      repeat (20) @(negedge clk);
      check("fl_no_tail", {31'd0, if_m.busy}, 32'd0);

      // reset between edges 3 and 4 of a word
      @(posedge clk);
      #1;
      send(8'hB4);
      repeat (3) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("ar_sout_m", {31'd0, if_m.sout}, 32'd0);
      check("ar_sout_l", {31'd0, if_l.sout}, 32'd1);
      check("ar_vld", {31'd0, if_m.sout_valid}, 32'd0);
      check("ar_last", {31'd0, if_m.word_last}, 32'd0);
      check("ar_busy", {31'd0, if_m.busy}, 32'd0);
      check("ar_rdy", {31'd0, if_m.din_ready}, 32'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      send(8'hFF);
      repeat (12) @(negedge clk);
      check("ff_run", last_run, 32'd8);

      // continuous valid with distinct words: hold stays full, nothing lost
      @(posedge clk);
      #1;
      din_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         din = 8'(i * 37 + 1);
         @(posedge clk);
         #1;
      end
      din_valid = 1'b0;
      repeat (20) @(posedge clk);

      // random traffic with occasional flush
      for (int i = 0; i < 1500; i++) begin
         #1;
         din       = 8'($urandom);
         din_valid = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 40) == 0);
         @(posedge clk);
      end
      #1;
      din_valid = 1'b0;
      flush     = 1'b0;
      repeat (30) @(posedge clk);
      @(negedge clk);
      check("drain_sb_m", sb_m.size(), 32'd0);
      check("drain_sb_l", sb_l.size(), 32'd0);
      check("drain_busy", {31'd0, if_m.busy}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/bit_serializer.md
# bit_serializer

Parallel-to-serial front end for the serial sequence-detector FSM. Accepts WIDTH-bit words over a valid/ready handshake, buffers one word, and shifts them out one bit per clock on `sout`, which drives the detector's 1-bit `in` port. A one-entry holding register lets consecutive words stream with no idle bit between them. `sout_valid` and `word_last` give the downstream stage and the bench frame information.

## Interface

Parameters:
- WIDTH, 8, word length in bits; legal range 2..32
- LSB_FIRST, 0, 0 = transmit bit WIDTH-1 first; 1 = transmit bit 0 first
- IDLE_LEVEL, 0, value driven on `sout` when no bit is being transmitted

Ports:
- clk  input  1  single clock; all state changes on rising edge
- rst_n  input  1  asynchronous, active-low reset
- din  input  WIDTH  parallel word to transmit
- din_valid  input  1  `din` is valid this cycle
- din_ready  output  1  block can accept a word this cycle
- flush  input  1  synchronous abort: drop the held word and the word being shifted
- sout  output  1  serial bit stream to the detector's `in`
- sout_valid  output  1  `sout` carries a data bit this cycle
- word_last  output  1  `sout` carries the final bit of a word this cycle
- busy  output  1  shifter active or hold register occupied

## Operation

- Storage: hold register `hold` plus `hold_full` flag; shift register `shreg` (WIDTH bits); bit counter `cnt` of width clog2(WIDTH); state.
- States: IDLE (shifter empty), SHIFT (shifter presenting a word).
- Accept: on a rising edge where `din_valid && din_ready`, `din` goes to `hold` and `hold_full` is set. `din_ready = !hold_full && !flush`. Combinational, with no dependency on `din_valid`.
- IDLE, `hold_full`=1: next edge loads `hold` into `shreg`, clears `hold_full`, sets `cnt`=WIDTH-1 and enters SHIFT.
- SHIFT: `sout` is the current head bit of `shreg`. That is `shreg[WIDTH-1]` when LSB_FIRST=0, or `shreg[0]` when LSB_FIRST=1. Each edge shifts `shreg` toward the head and decrements `cnt`.
- SHIFT with `cnt`==0, which is the last bit:
  - If `hold_full`=1, the next edge loads `hold` into `shreg`, clears `hold_full`, sets `cnt`=WIDTH-1 and stays in SHIFT. This is the gapless case.
  - Otherwise the next edge goes to IDLE.
- The hold register cannot load and unload on the same edge. `din_ready` is low whenever `hold_full`=1, so the next accept happens at the earliest one edge after the hold is emptied.
- Outputs:
  - `sout_valid` = (state==SHIFT).
  - `word_last` = SHIFT && `cnt`==0.
  - `sout` = IDLE_LEVEL when `sout_valid`=0.
  - `busy` = SHIFT || `hold_full`.
- Flush: a rising edge with `flush`=1 clears `hold_full`, goes to IDLE and zeroes `cnt`. A `din` presented in that cycle is not accepted, because `din_ready` is low. Flush takes priority over every other transition.
- Reset (`rst_n`=0, any time, including mid-word):
  - Effect is immediate.
  - State=IDLE, `hold_full`=0, `shreg`=0, `cnt`=0.
  - Outputs: `sout`=IDLE_LEVEL, `sout_valid`=0, `word_last`=0, `busy`=0, `din_ready`=1.
  - Partial words are discarded.
  - After deassertion, the first edge can accept.

## Timing

- Edge numbering: word accepted at edge E. Load into `shreg` at edge E+1 if IDLE. Bit k of the transmit order (k=0..WIDTH-1) is on `sout` in the cycle after edge E+1+k.
- Latency from accept edge to the first bit on `sout`: 1 cycle.
- Sustained throughput: one word per WIDTH cycles, with no gap cycles, provided each next word is accepted before the current word's last-bit edge.
- `din_ready` falls in the cycle after an accept. It rises in the cycle after the hold unloads.
- `word_last` is high for exactly one cycle per transmitted word, coincident with that word's final bit.
- `sout`, `sout_valid` and `word_last` change only after rising edges or on reset assertion, so the detector samples a stable bit on the next edge.

## Test plan

- Single word, WIDTH=8, LSB_FIRST=0, `din`=8'hB4 accepted at edge 0:
  - `sout` = 1,0,1,1,0,1,0,0 in cycles after edges 1..8.
  - `word_last` high only after edge 8.
  - IDLE with `sout`=0 and `busy`=0 after edge 9.
- Back-to-back: 8'hB4 at edge 0, 8'h5A at edge 2:
  - 16 contiguous valid bits: 10110100 then 01011010.
  - `sout_valid` never drops between the two words.
  - `din_ready` low after edge 2 until the hold unloads at edge 9.
- Hold full: hold `din_valid`=1 continuously with distinct words:
  - `din_ready` low in every cycle with `hold_full`=1.
  - No word is lost or duplicated; output order matches input order.
- LSB_FIRST=1, `din`=8'hB4: `sout` = 0,0,1,0,1,1,0,1.
- Flush after edge 4 of word 8'hB4 with 8'h5A held:
  - Next cycle: `sout_valid`=0, `busy`=0, `sout`=IDLE_LEVEL.
  - No bits of 8'h5A appear.
- Reset mid-word: assert `rst_n`=0 between edges 3 and 4:
  - All outputs go immediately to their reset values.
  - After release, 8'hFF accepted at the first edge transmits eight 1s cleanly.
